// File: rtl/rsa_mont_arbiter_if.sv
// rsa_mont_arbiter_if: requester-side and multiplier-side handshakes of the Montgomery arbiter.
// The arbiter connects through master; the requesters and multiplier stub connect through slave.
interface rsa_mont_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int MOD_WIDTH = 256
);
    logic [N_REQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N_REQ-1:0][3*MOD_WIDTH-1:0] req_data;
    logic [MOD_WIDTH-1:0] rsp_data, mont_o_data;
    logic [3*MOD_WIDTH-1:0] mont_i_data;
    logic mont_i_valid, mont_i_ready, mont_o_valid, mont_o_ready;
    modport master (
        input  req_valid, req_data, rsp_ready, mont_i_ready, mont_o_valid, mont_o_data,
        output req_ready, rsp_valid, rsp_data, mont_i_valid, mont_i_data, mont_o_ready
    );
    modport slave (
        output req_valid, req_data, rsp_ready, mont_i_ready, mont_o_valid, mont_o_data,
        input  req_ready, rsp_valid, rsp_data, mont_i_valid, mont_i_data, mont_o_ready
    );
endinterface

// File: rtl/rsa_mont_arbiter.sv
// rsa_mont_arbiter: round-robin sharing of one Montgomery multiplier among N_REQ requesters,
// one transaction in flight, operands and result passed through registered and unmodified.
module rsa_mont_arbiter #(
    parameter int N_REQ = 2,
    parameter int MOD_WIDTH = 256,
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic clk,
    input  logic rst,
    rsa_mont_arbiter_if.master bus,
    output logic busy,
    output logic [GW-1:0] grant_id,
    output logic proto_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;
    stateT state, nextState;
    logic [GW-1:0] lastId, winner, cand;
    logic found, accept, resultHs, respHs;
    logic [3*MOD_WIDTH-1:0] opReg;
    logic [MOD_WIDTH-1:0] resReg;

    // Search starts just after the previous owner so every waiting port is reached within N_REQ rounds
    always_comb begin
        winner = '0;
        found = 1'b0;
        cand = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = GW'((int'(lastId) + k) % N_REQ);
            if (!found && bus.req_valid[cand]) begin
                winner = cand;
                found = 1'b1;
            end
        end
    end

    assign accept = (state == IDLE) && found && !rst;
    assign resultHs = (state == WAIT) && bus.mont_o_valid;
    assign respHs = (state == RESP) && bus.rsp_ready[grant_id];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = found ? ISSUE : IDLE;
            ISSUE:   nextState = bus.mont_i_ready ? WAIT : ISSUE;
            WAIT:    nextState = bus.mont_o_valid ? RESP : WAIT;
            RESP:    nextState = bus.rsp_ready[grant_id] ? IDLE : RESP;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastId <= GW'(N_REQ - 1);
            grant_id <= '0;
            opReg <= '0;
            resReg <= '0;
            proto_err <= 1'b0;
        end else begin
            if (accept) begin
                opReg <= bus.req_data[winner];
                grant_id <= winner;
            end
            if (resultHs) resReg <= bus.mont_o_data;
            if (respHs) lastId <= grant_id;
            if (bus.mont_o_valid && state != WAIT) proto_err <= 1'b1;
        end
    end

    always_comb begin
        bus.req_ready = accept ? N_REQ'(1) << winner : '0;
        bus.rsp_valid = (state == RESP) ? N_REQ'(1) << grant_id : '0;
        bus.rsp_data = resReg;
        bus.mont_i_valid = state == ISSUE;
        bus.mont_i_data = opReg;
        bus.mont_o_ready = state == WAIT;
        busy = state != IDLE;
    end
endmodule
